// File: rtl/aes_sec_feeder_pkg.sv
// Shared definitions for the AES cipher-interface feeder.
//   KS_*            key-size encodings seen on cmd_key_size
//   feedState_t     feeder sequencing states
//   outEntry_t      one output-buffer entry (last marker + 128-bit block)
//   keySizeOneHot   maps a key-size code to {Aes256, Aes192, Aes128}
package aes_sec_feeder_pkg;

  localparam logic [1:0] KS_128 = 2'd0;
  localparam logic [1:0] KS_192 = 2'd1;
  localparam logic [1:0] KS_256 = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    LOAD,
    SEND,
    DRAIN
  } feedState_t;

  typedef struct packed {
    logic         last;
    logic [127:0] data;
  } outEntry_t;

  // Code 3 is not a real key size; it is folded onto 256.
  function automatic logic [2:0] keySizeOneHot(input logic [1:0] keySize);
    logic [2:0] oneHot;
    case (keySize)
      KS_128:  oneHot = 3'b001;
      KS_192:  oneHot = 3'b010;
      KS_256:  oneHot = 3'b100;
      default: oneHot = 3'b100;
    endcase
    return oneHot;
  endfunction

endpackage

// File: rtl/aes_sec_out_fifo.sv
// Synchronous FIFO holding engine output blocks until downstream accepts them.
//   clk, rst_n   clock, async active-low reset (clears pointers, occupancy and storage)
//   wrEn/wrData  push request; ignored while full
//   rdEn         pop request; ignored while empty
//   rdData       head entry
//   full, empty  derived from the registered occupancy counter
module aes_sec_out_fifo
  import aes_sec_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wrEn,
  input  outEntry_t wrData,
  input  logic      rdEn,
  output outEntry_t rdData,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

  outEntry_t        mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   occ;
  logic             doWrite;
  logic             doRead;

  assign full    = (occ == DEPTH_CNT);
  assign empty   = (occ == '0);
  assign doWrite = wrEn && !full;
  assign doRead  = rdEn && !empty;
  assign rdData  = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (doWrite) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (doRead) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({doWrite, doRead})
        2'b10:   occ <= occ + (PTR_W + 1)'(1);
        2'b01:   occ <= occ - (PTR_W + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/aes_sec_feeder.sv
// Drives the AES engine cipher interface for one frame per command:
// issues key init, packs 64-bit upstream words into 128-bit blocks, and
// returns engine output to a 128-bit downstream port with the frame-last
// marker restored.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a frame command
// KEY   | key init request held until the engine takes it
// LOAD  | collecting one or two 64-bit words into the block register
// SEND  | block presented to the engine, held while stalled
// DRAIN | last block issued, waiting for every output to leave
//
// Ports
//   cmd_*            frame command (key, key size, direction)
//   din*             64-bit upstream stream with frame-last marker
//   dout*            128-bit downstream stream with frame-last marker
//   Aes128/192/256   one-hot key size to engine, held for the frame
//   KeyIn, KeyInitVldR, KeyInitStall        engine key init handshake
//   EncryptEn        direction to engine, held for the frame
//   CiphIn, CiphInVldR, CiphInLastR, CiphInStall   engine block input
//   AesCiphOutR, AesCiphOutVldR, AesCiphOutStall   engine block output
module aes_sec_feeder
  import aes_sec_feeder_pkg::*;
#(
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_vld,
  output logic         cmd_rdy,
  input  logic [255:0] cmd_key,
  input  logic [1:0]   cmd_key_size,
  input  logic         cmd_encrypt,
  input  logic [63:0]  din,
  input  logic         din_vld,
  input  logic         din_last,
  output logic         din_rdy,
  output logic [127:0] dout,
  output logic         dout_vld,
  output logic         dout_last,
  input  logic         dout_rdy,
  output logic         Aes128,
  output logic         Aes192,
  output logic         Aes256,
  output logic [255:0] KeyIn,
  output logic         KeyInitVldR,
  input  logic         KeyInitStall,
  output logic         EncryptEn,
  output logic [127:0] CiphIn,
  output logic         CiphInVldR,
  output logic         CiphInLastR,
  input  logic         CiphInStall,
  input  logic [127:0] AesCiphOutR,
  input  logic         AesCiphOutVldR,
  output logic         AesCiphOutStall
);

  feedState_t       state;
  logic             halfSel;
  logic             lastIssued;
  logic [CNT_W-1:0] issueCnt;
  logic [CNT_W-1:0] retCnt;

  outEntry_t        pushEntry;
  outEntry_t        headEntry;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pushEn;
  logic             popEn;

  // A returning block closes the frame only once the frame's last block has
  // gone out and this is the final outstanding return.
  assign AesCiphOutStall = fifoFull;
  assign pushEn          = AesCiphOutVldR && !fifoFull && (state != IDLE);
  assign pushEntry       = '{last: lastIssued && ((retCnt + CNT_W'(1)) == issueCnt),
                             data: AesCiphOutR};

  assign dout_vld  = !fifoEmpty;
  assign dout      = headEntry.data;
  assign dout_last = headEntry.last && !fifoEmpty;
  assign popEn     = dout_vld && dout_rdy;

  aes_sec_out_fifo #(
    .DEPTH (OUT_DEPTH)
  ) uOutFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (pushEn),
    .wrData (pushEntry),
    .rdEn   (popEn),
    .rdData (headEntry),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_rdy     <= 1'b0;
      din_rdy     <= 1'b0;
      KeyIn       <= '0;
      Aes128      <= 1'b0;
      Aes192      <= 1'b0;
      Aes256      <= 1'b0;
      EncryptEn   <= 1'b0;
      KeyInitVldR <= 1'b0;
      CiphIn      <= '0;
      CiphInVldR  <= 1'b0;
      CiphInLastR <= 1'b0;
      halfSel     <= 1'b0;
      lastIssued  <= 1'b0;
      issueCnt    <= '0;
      retCnt      <= '0;
    end else begin
      if (pushEn) begin
        retCnt <= retCnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          cmd_rdy <= 1'b1;
          if (cmd_vld && cmd_rdy) begin
            cmd_rdy                  <= 1'b0;
            KeyIn                    <= cmd_key;
            {Aes256, Aes192, Aes128} <= keySizeOneHot(cmd_key_size);
            EncryptEn                <= cmd_encrypt;
            KeyInitVldR              <= 1'b1;
            state                    <= KEY;
          end
        end

        KEY: begin
          if (KeyInitVldR && !KeyInitStall) begin
            KeyInitVldR <= 1'b0;
            din_rdy     <= 1'b1;
            halfSel     <= 1'b0;
            state       <= LOAD;
          end
        end

        LOAD: begin
          if (din_vld && din_rdy) begin
            if (!halfSel) begin
              // Upper half is pre-zeroed so a single-word block is padded.
              CiphIn <= {64'h0, din};
              if (din_last) begin
                din_rdy     <= 1'b0;
                CiphInVldR  <= 1'b1;
                CiphInLastR <= 1'b1;
                state       <= SEND;
              end else begin
                halfSel <= 1'b1;
              end
            end else begin
              CiphIn[127:64] <= din;
              halfSel        <= 1'b0;
              din_rdy        <= 1'b0;
              CiphInVldR     <= 1'b1;
              CiphInLastR    <= din_last;
              state          <= SEND;
            end
          end
        end

        SEND: begin
          if (CiphInVldR && !CiphInStall) begin
            CiphInVldR  <= 1'b0;
            CiphInLastR <= 1'b0;
            issueCnt    <= issueCnt + CNT_W'(1);
            if (CiphInLastR) begin
              lastIssued <= 1'b1;
              state      <= DRAIN;
            end else begin
              din_rdy <= 1'b1;
              state   <= LOAD;
            end
          end
        end

        DRAIN: begin
          if ((retCnt == issueCnt) && fifoEmpty) begin
            issueCnt   <= '0;
            retCnt     <= '0;
            lastIssued <= 1'b0;
            cmd_rdy    <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sec_feeder.sv
// Scoreboard bench for aes_sec_feeder: an engine model answers the cipher
// interface, expected blocks and outputs are queued when frames are issued,
// and a negedge monitor pops and compares on every handshake.
module tb_aes_sec_feeder;

  localparam int OUT_DEPTH = 4;
  localparam int CNT_W     = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_vld, cmd_rdy, cmd_encrypt;
  logic [255:0] cmd_key;
  logic [1:0]   cmd_key_size;
  logic [63:0]  din;
  logic         din_vld, din_last, din_rdy;
  logic [127:0] dout;
  logic         dout_vld, dout_last, dout_rdy;
  logic         Aes128, Aes192, Aes256;
  logic [255:0] KeyIn;
  logic         KeyInitVldR, KeyInitStall, EncryptEn;
  logic [127:0] CiphIn;
  logic         CiphInVldR, CiphInLastR, CiphInStall;
  logic [127:0] AesCiphOutR;
  logic         AesCiphOutVldR, AesCiphOutStall;

  aes_sec_feeder #(.OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_key(cmd_key),
    .cmd_key_size(cmd_key_size), .cmd_encrypt(cmd_encrypt),
    .din(din), .din_vld(din_vld), .din_last(din_last), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_last(dout_last), .dout_rdy(dout_rdy),
    .Aes128(Aes128), .Aes192(Aes192), .Aes256(Aes256),
    .KeyIn(KeyIn), .KeyInitVldR(KeyInitVldR), .KeyInitStall(KeyInitStall),
    .EncryptEn(EncryptEn),
    .CiphIn(CiphIn), .CiphInVldR(CiphInVldR), .CiphInLastR(CiphInLastR),
    .CiphInStall(CiphInStall),
    .AesCiphOutR(AesCiphOutR), .AesCiphOutVldR(AesCiphOutVldR),
    .AesCiphOutStall(AesCiphOutStall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         last;
    logic [127:0] data;
  } blk_t;

  typedef struct {
    logic [255:0] key;
    logic [2:0]   oneHot;
    logic         enc;
  } keyRec_t;

  int errors = 0;
  int checks = 0;

  blk_t         expBlkQ[$];
  blk_t         expOutQ[$];
  keyRec_t      expKeyQ[$];
  keyRec_t      curKey;
  logic [127:0] engQ[$];
  logic [63:0]  words[$];

  bit           engConst = 0;
  bit           randStall = 0;
  int           rdyMode = 1;       // 0 low, 1 high, 2 random, 3 one-cycle pulse
  int           keyStallLeft = 0;
  int           ciphStallLeft = 0;
  int           keyStallCnt = 0;
  int           ciphStallCnt = 0;
  int           captures = 0;

  bit           ciphXferF = 0;
  bit           outXferF = 0;
  logic [127:0] ciphDataF;
  bit           prevStalled = 0;
  logic [128:0] prevBlk;

  task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired, condition never became true", name);
  endtask

  // Stand-in cipher: any bijection works since the bench only needs to know
  // which input block each output belongs to.
  function automatic logic [127:0] engFn(input logic [127:0] b);
    if (engConst) return 128'hA5;
    return {b[63:0], b[127:64]} ^ 128'hC3C3_5A5A_0F0F_9696_1234_5678_9ABC_DEF0;
  endfunction

  // Reference model: pair words low-then-high, zero-pad an odd final word,
  // last flag only on the final block of the frame.
  task automatic pushFrame();
    int n;
    blk_t b;
    n = words.size();
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) b.data = {words[i+1], words[i]};
      else           b.data = {64'h0, words[i]};
      b.last = (i + 2 >= n);
      expBlkQ.push_back(b);
      expOutQ.push_back('{last: b.last, data: engFn(b.data)});
    end
  endtask

  task automatic genWords(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
  endtask

  task automatic sendCmd(input logic [255:0] key, input logic [1:0] ks, input logic enc);
    keyRec_t r;
    int n;
    r.key    = key;
    r.oneHot = (ks == 2'd0) ? 3'b001 : (ks == 2'd1) ? 3'b010 : 3'b100;
    r.enc    = enc;
    cmd_key = key; cmd_key_size = ks; cmd_encrypt = enc; cmd_vld = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_rdy && n < 3000);
    if (!cmd_rdy) begin
      timeoutFail("cmd_accept");
      cmd_vld = 1'b0;
      return;
    end
    expKeyQ.push_back(r);
    chk("cmd_accept_after_drain", 272'(expOutQ.size()), 272'(0));
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    @(negedge clk);
    chk("keyinit_rise", 272'(KeyInitVldR), 272'(1));
    @(posedge clk); #1;
  endtask

  task automatic sendWords(input int nSend, input bit gaps);
    int n;
    for (int i = 0; i < nSend; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      din = words[i]; din_last = (i == words.size() - 1); din_vld = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!din_rdy && n < 3000);
      if (!din_rdy) begin
        timeoutFail("din_accept");
        din_vld = 1'b0; din_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
      din_vld = 1'b0; din_last = 1'b0;
    end
  endtask

  task automatic runFrame(input logic [255:0] key, input logic [1:0] ks,
                          input logic enc, input bit gaps);
    sendCmd(key, ks, enc);
    pushFrame();
    sendWords(words.size(), gaps);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(cmd_rdy && expOutQ.size() == 0 && expBlkQ.size() == 0) && n < 5000);
    if (!(cmd_rdy && expOutQ.size() == 0 && expBlkQ.size() == 0)) timeoutFail(name);
    @(posedge clk); #1;
  endtask

  // Monitor: everything sampled mid-cycle, where the coming edge's
  // handshakes are already determined.
  always @(negedge clk) begin : monitorBlk
    blk_t    b;
    keyRec_t r;
    if (!rst_n) begin
      ciphXferF   = 0;
      outXferF    = 0;
      prevStalled = 0;
    end else begin
      if (KeyInitVldR && KeyInitStall) keyStallCnt++;
      if (KeyInitVldR && !KeyInitStall) begin
        if (expKeyQ.size() == 0) timeoutFail("key_unexpected");
        else begin
          r = expKeyQ.pop_front();
          curKey = r;
          chk("key_in", KeyIn, r.key);
          chk("key_size", 272'({Aes256, Aes192, Aes128}), 272'(r.oneHot));
          chk("key_dir", 272'(EncryptEn), 272'(r.enc));
        end
      end

      ciphXferF = 0;
      if (CiphInVldR) begin
        if (prevStalled) chk("ciph_hold", 272'({CiphInLastR, CiphIn}), 272'(prevBlk));
        if (CiphInStall) begin
          ciphStallCnt++;
          prevStalled = 1;
          prevBlk     = {CiphInLastR, CiphIn};
        end else begin
          prevStalled = 0;
          ciphXferF   = 1;
          ciphDataF   = CiphIn;
          if (expBlkQ.size() == 0) timeoutFail("ciph_unexpected");
          else begin
            b = expBlkQ.pop_front();
            chk("ciph_blk", 272'({CiphInLastR, CiphIn}), 272'(b));
            chk("frame_size_dir", 272'({Aes256, Aes192, Aes128, EncryptEn}),
                272'({curKey.oneHot, curKey.enc}));
          end
        end
      end else begin
        prevStalled = 0;
      end

      outXferF = AesCiphOutVldR && !AesCiphOutStall;
      if (outXferF) captures++;

      if (dout_vld && dout_rdy) begin
        if (expOutQ.size() == 0) timeoutFail("dout_unexpected");
        else begin
          b = expOutQ.pop_front();
          chk("dout", 272'({dout_last, dout}), 272'(b));
        end
      end
    end
  end

  // Engine model and downstream ready, updated just after each rising edge.
  initial begin
    KeyInitStall = 0; CiphInStall = 0; AesCiphOutVldR = 0; AesCiphOutR = '0; dout_rdy = 0;
    forever begin
      @(posedge clk); #1;
      if (ciphXferF) engQ.push_back(engFn(ciphDataF));
      if (outXferF && engQ.size() > 0) void'(engQ.pop_front());

      if (KeyInitVldR && keyStallLeft > 0) begin
        KeyInitStall = 1; keyStallLeft--;
      end else KeyInitStall = randStall && ($urandom_range(0, 2) == 0);

      if (CiphInVldR && ciphStallLeft > 0) begin
        CiphInStall = 1; ciphStallLeft--;
      end else CiphInStall = randStall && ($urandom_range(0, 2) == 0);

      if (engQ.size() > 0 && (!randStall || $urandom_range(0, 3) != 0)) begin
        AesCiphOutVldR = 1; AesCiphOutR = engQ[0];
      end else AesCiphOutVldR = 0;

      case (rdyMode)
        0: dout_rdy = 0;
        1: dout_rdy = 1;
        3: begin dout_rdy = 1; rdyMode = 0; end
        default: dout_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : mainBlk
    int n;
    rst_n = 0; cmd_vld = 0; cmd_key = '0; cmd_key_size = '0; cmd_encrypt = 0;
    din = '0; din_vld = 0; din_last = 0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_ctl", 272'({cmd_rdy, din_rdy, dout_vld, dout_last, KeyInitVldR, CiphInVldR,
                         CiphInLastR, AesCiphOutStall, Aes128, Aes192, Aes256, EncryptEn}), 272'(0));
    chk("rst_key", KeyIn, 272'(0));
    chk("rst_data", 272'({CiphIn, dout}), 272'(0));
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("cmd_rdy_after_rst", 272'(cmd_rdy), 272'(1));

    // Two-word 128-bit encrypt frame, engine returns a constant
    engConst = 1; rdyMode = 1;
    words.delete(); words.push_back(64'h1111); words.push_back(64'h2222);
    runFrame({128'h0, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}, 2'd0, 1'b1, 1'b0);
    waitIdle("idle_frame1");
    chk("idle_after_frame1", 272'(cmd_rdy), 272'(1));
    engConst = 0;

    // Three-word frame with key and block stalls
    keyStallCnt = 0; ciphStallCnt = 0; keyStallLeft = 5; ciphStallLeft = 3;
    genWords(3);
    runFrame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             2'd1, 1'b0, 1'b0);
    waitIdle("idle_frame2");
    chk("key_stall_cycles", 272'(keyStallCnt), 272'(5));
    chk("ciph_stall_cycles", 272'(ciphStallCnt), 272'(3));

    // Output buffer fills with downstream blocked
    rdyMode = 0; captures = 0;
    genWords(12);
    runFrame({8{$urandom}}, 2'd2, 1'b1, 1'b0);
    n = 0;
    do begin
      @(posedge clk); #2; n++;
      chk("stall_vs_occupancy", 272'(AesCiphOutStall), 272'(captures >= OUT_DEPTH));
    end while (!(captures == OUT_DEPTH && engQ.size() == 2 && expBlkQ.size() == 0) && n < 500);
    if (!(captures == OUT_DEPTH && engQ.size() == 2)) timeoutFail("fill_buffer");
    repeat (3) @(posedge clk); #2;
    chk("no_capture_while_full", 272'(captures), 272'(OUT_DEPTH));
    rdyMode = 3;
    repeat (2) @(posedge clk); #2;
    chk("pop_cycle_push_blocked", 272'({AesCiphOutStall, 8'(captures)}), 272'({1'b0, 8'(OUT_DEPTH)}));
    @(posedge clk); #2;
    chk("push_after_pop", 272'({AesCiphOutStall, 8'(captures)}), 272'({1'b1, 8'(OUT_DEPTH + 1)}));
    #1 rdyMode = 1;
    waitIdle("idle_frame3");

    // Asynchronous reset while a block is stalled in SEND
    ciphStallLeft = 1000;
    genWords(4);
    sendCmd({8{$urandom}}, 2'd0, 1'b1);
    sendWords(2, 1'b0);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!CiphInVldR && n < 100);
    if (!CiphInVldR) timeoutFail("reach_send");
    rst_n = 0;
    #1;
    chk("async_rst_ctl", 272'({cmd_rdy, din_rdy, dout_vld, dout_last, KeyInitVldR, CiphInVldR,
                               CiphInLastR, AesCiphOutStall, Aes128, Aes192, Aes256, EncryptEn}),
        272'(0));
    chk("async_rst_key", KeyIn, 272'(0));
    chk("async_rst_data", 272'({CiphIn, dout}), 272'(0));
    ciphStallLeft = 0; keyStallLeft = 0;
    expBlkQ.delete(); expOutQ.delete(); expKeyQ.delete(); engQ.delete();
    repeat (2) @(posedge clk); #2;
    rst_n = 1;
    @(posedge clk); #1;
    chk("cmd_rdy_after_midframe_rst", 272'(cmd_rdy), 272'(1));
    genWords(5);
    runFrame({8{$urandom}}, 2'd1, 1'b1, 1'b1);
    waitIdle("idle_after_rst");

    // Key size 3, then a back-to-back frame under random stalls
    randStall = 1; rdyMode = 2;
    genWords(6);
    runFrame({8{$urandom}}, 2'd3, 1'b0, 1'b0);
    genWords(1);
    runFrame({8{$urandom}}, 2'd3, 1'b1, 1'b0);

    // Random frames
    for (int f = 0; f < 20; f++) begin
      genWords($urandom_range(1, 9));
      runFrame({8{$urandom}}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
    end
    waitIdle("idle_random");
    chk("queues_empty", 272'({16'(expKeyQ.size()), 16'(engQ.size())}), 272'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
